// File: rtl/mem_init_pkg.sv
// Shared types and constants for the boot-time flash-to-SRAM copy engine.
package common;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } mem_init_state_t;

    // Byte offset of the boot image inside the flash device.
    localparam logic [23:0] FLASH_ROM_OFFSET = 24'h013256;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_init_timeout.sv
// Loadable down-counter bounding how long the copy engine waits for one flash byte.
module mem_init_timeout #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic expired
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CW'(TIMEOUT);
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    // High during the last permitted wait cycle, so the wait lasts exactly TIMEOUT cycles.
    assign expired = (count_reg <= CW'(1));

endmodule

// File: rtl/mem_init.sv
// Copies a table of flash regions into SRAM byte by byte after reset or on request,
// keeping a 16-bit running checksum of the copied data.
module mem_init
    import common::*;
#(
    parameter int unsigned FLASH_AW = 24,
    parameter int unsigned RAM_AW   = 19,
    parameter int unsigned LEN_W    = 17,
    parameter int unsigned REGIONS  = 2,
    parameter logic [REGIONS*FLASH_AW-1:0] REGION_SRC = {REGIONS{FLASH_AW'(FLASH_ROM_OFFSET)}},
    parameter logic [REGIONS*RAM_AW-1:0]   REGION_DST = '0,
    parameter logic [REGIONS*LEN_W-1:0]    REGION_LEN = {REGIONS{LEN_W'(4)}},
    parameter int unsigned TIMEOUT  = 1024,
    parameter bit AUTO_START        = 1'b1
) (
    input  logic                clk28,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         checksum,
    output logic                flash_req,
    output logic [FLASH_AW-1:0] flash_addr,
    input  logic                flash_valid,
    input  logic [7:0]          flash_data,
    output logic                ram_wr,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [7:0]          ram_data,
    input  logic                ram_ack
);

    localparam int unsigned RIDX_W = idx_width(REGIONS);
    localparam logic [RIDX_W-1:0] LAST_REGION = RIDX_W'(REGIONS - 1);

    logic [FLASH_AW-1:0] region_src [REGIONS];
    logic [RAM_AW-1:0]   region_dst [REGIONS];
    logic [LEN_W-1:0]    region_len [REGIONS];

    generate
        for (genvar gi = 0; gi < REGIONS; gi++) begin : g_region
            assign region_src[gi] = REGION_SRC[gi*FLASH_AW +: FLASH_AW];
            assign region_dst[gi] = REGION_DST[gi*RAM_AW +: RAM_AW];
            assign region_len[gi] = REGION_LEN[gi*LEN_W +: LEN_W];
        end
    endgenerate

    mem_init_state_t     state_reg, state_next;
    logic [RIDX_W-1:0]   region_reg;
    logic [FLASH_AW-1:0] src_reg;
    logic [RAM_AW-1:0]   dst_reg;
    logic [LEN_W-1:0]    len_reg;
    logic [15:0]         checksum_reg;
    logic [7:0]          data_reg;

    logic [LEN_W-1:0]    cur_len;
    logic [LEN_W-1:0]    len_dec;
    logic                last_region;
    logic                tmo_expired;

    assign cur_len     = region_len[region_reg];
    assign len_dec     = len_reg - LEN_W'(1);
    assign last_region = (region_reg == LAST_REGION);

    mem_init_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk28   (clk28),
        .rst_n   (rst_n),
        .load    (state_reg == ST_REQ),
        .dec     (state_reg == ST_WAIT),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start || AUTO_START) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cur_len != '0) begin
                    state_next = ST_REQ;
                end else if (last_region) begin
                    state_next = ST_DONE;
                end
            end
            ST_REQ: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (flash_valid) begin
                    state_next = ST_WRITE;
                end else if (tmo_expired) begin
                    state_next = ST_ERR;
                end
            end
            ST_WRITE: begin
                if (ram_ack) begin
                    if (len_dec != '0) begin
                        state_next = ST_REQ;
                    end else if (last_region) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            region_reg   <= '0;
            src_reg      <= '0;
            dst_reg      <= '0;
            len_reg      <= '0;
            checksum_reg <= '0;
            data_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    // A (re)start always begins a fresh copy from the first region.
                    if (state_next == ST_LOAD) begin
                        region_reg   <= '0;
                        checksum_reg <= '0;
                    end
                end
                ST_LOAD: begin
                    if (cur_len != '0) begin
                        src_reg <= region_src[region_reg];
                        dst_reg <= region_dst[region_reg];
                        len_reg <= cur_len;
                    end else if (!last_region) begin
                        region_reg <= region_reg + RIDX_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (flash_valid) begin
                        data_reg     <= flash_data;
                        checksum_reg <= checksum_reg + {8'h00, flash_data};
                    end
                end
                ST_WRITE: begin
                    if (ram_ack) begin
                        src_reg <= src_reg + FLASH_AW'(1);
                        dst_reg <= dst_reg + RAM_AW'(1);
                        len_reg <= len_dec;
                        if ((len_dec == '0) && !last_region) begin
                            region_reg <= region_reg + RIDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control outputs decode straight from the state register so reset clears them at once.
    assign busy       = (state_reg == ST_LOAD) || (state_reg == ST_REQ) ||
                        (state_reg == ST_WAIT) || (state_reg == ST_WRITE);
    assign done       = (state_reg == ST_DONE);
    assign error      = (state_reg == ST_ERR);
    assign flash_req  = (state_reg == ST_REQ);
    assign ram_wr     = (state_reg == ST_WRITE);
    assign flash_addr = src_reg;
    assign ram_addr   = dst_reg;
    assign ram_data   = data_reg;
    assign checksum   = checksum_reg;

endmodule

// File: tb/tb_mem_init.sv
// Directed bench for mem_init: three-region table (empty, boot image, wrapping region),
// scoreboarded flash requests and SRAM writes.
module tb_mem_init;

    logic        clk28 = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, error;
    logic [15:0] checksum;
    logic        flash_req;
    logic [23:0] flash_addr;
    logic        flash_valid;
    logic [7:0]  flash_data;
    logic        ram_wr;
    logic [18:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_ack;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [23:0] t_src [3];
    logic [18:0] t_dst [3];
    int          t_len [3];

    logic [23:0] q_faddr [$];
    logic [26:0] q_wr [$];

    int req_cnt = 0;
    int req_cyc = 0;
    int wr_idx  = 0;
    int stall_target = -1;
    int stall_cnt    = 0;
    logic stray_ack  = 1'b0;
    int answer_limit = 1 << 30;
    int answered     = 0;
    int stray_req    = 0;
    int stray_done   = 0;

    mem_init #(
        .FLASH_AW   (24),
        .RAM_AW     (19),
        .LEN_W      (17),
        .REGIONS    (3),
        .REGION_SRC ({24'h000156, 24'h013256, 24'h000000}),
        .REGION_DST ({19'h7FFFE, 19'h00000, 19'h12345}),
        .REGION_LEN ({17'd4, 17'd4, 17'd0}),
        .TIMEOUT    (16),
        .AUTO_START (1'b1)
    ) dut (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .checksum    (checksum),
        .flash_req   (flash_req),
        .flash_addr  (flash_addr),
        .flash_valid (flash_valid),
        .flash_data  (flash_data),
        .ram_wr      (ram_wr),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_ack     (ram_ack)
    );

    always #5 clk28 = ~clk28;
    always @(posedge clk28) cyc <= cyc + 1;

    assign ram_ack = (ram_wr && (stall_cnt == 0)) || stray_ack;

    function automatic logic [7:0] fdata(input logic [23:0] a);
        return a[7:0] - 8'h55;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_run();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < t_len[r]; i++) begin
                logic [23:0] s;
                logic [18:0] d;
                s = t_src[r] + 24'(i);
                d = t_dst[r] + 19'(i);
                q_faddr.push_back(s);
                q_wr.push_back({d, fdata(s)});
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk28);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk28);
            n++;
        end
        chk(tag, 32'(done | error), 32'd1);
    endtask

    // Flash model: answers three cycles after a request, up to answer_limit bytes.
    initial begin
        logic [23:0] a;
        flash_valid = 1'b0;
        flash_data  = 8'h00;
        forever begin
            @(negedge clk28);
            if (rst_n && flash_req && answered < answer_limit) begin
                a = flash_addr;
                answered++;
                repeat (3) @(negedge clk28);
                flash_valid = 1'b1;
                flash_data  = fdata(a);
                @(negedge clk28);
                flash_valid = 1'b0;
                flash_data  = 8'h00;
            end else if (stray_req > stray_done) begin
                stray_done++;
                flash_valid = 1'b1;
                flash_data  = 8'hFF;
                @(negedge clk28);
                flash_valid = 1'b0;
                flash_data  = 8'h00;
            end
        end
    end

    always @(negedge clk28) begin
        if (rst_n && flash_req) begin
            req_cnt++;
            req_cyc = cyc;
            if (q_faddr.size() == 0) begin
                chk("unexpected_req", 32'(flash_addr), 32'hFFFFFFFF);
            end else begin
                chk("flash_addr", 32'(flash_addr), 32'(q_faddr.pop_front()));
            end
            chk("req_during_wr", 32'(ram_wr), 32'd0);
        end
    end

    logic        prev_wr = 1'b0;
    logic [18:0] hold_addr;
    logic [7:0]  hold_data;
    logic [26:0] exp_wr;

    always @(negedge clk28) begin
        if (!rst_n) begin
            stall_cnt = 0;
            prev_wr   = 1'b0;
        end else begin
            if (ram_wr) begin
                if (!prev_wr && wr_idx == stall_target) begin
                    stall_cnt = 21;
                    hold_addr = ram_addr;
                    hold_data = ram_data;
                end
                if (stall_cnt != 0) stall_cnt--;
                if (stall_cnt == 0 || stray_ack) begin
                    if (q_wr.size() == 0) begin
                        chk("unexpected_wr", 32'(ram_addr), 32'hFFFFFFFF);
                    end else begin
                        exp_wr = q_wr.pop_front();
                        chk("wr_addr", 32'(ram_addr), 32'(exp_wr[26:8]));
                        chk("wr_data", 32'(ram_data), 32'(exp_wr[7:0]));
                    end
                    $display("write %0d addr=%05h data=%02h chk=%04h", wr_idx, ram_addr, ram_data, checksum);
                    wr_idx++;
                end else begin
                    chk("stall_addr", 32'(ram_addr), 32'(hold_addr));
                    chk("stall_data", 32'(ram_data), 32'(hold_data));
                    chk("stall_req", 32'(flash_req), 32'd0);
                end
            end
            prev_wr = ram_wr;
        end
    end

    initial begin
        int n;
        int base;
        t_src[0] = 24'h000000; t_dst[0] = 19'h12345; t_len[0] = 0;
        t_src[1] = 24'h013256; t_dst[1] = 19'h00000; t_len[1] = 4;
        t_src[2] = 24'h000156; t_dst[2] = 19'h7FFFE; t_len[2] = 4;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk28);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_req", 32'(flash_req), 32'd0);
        chk("rst_wr", 32'(ram_wr), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_faddr", 32'(flash_addr), 32'd0);
        chk("rst_raddr", 32'(ram_addr), 32'd0);

        // Run 1: auto start, stall on the second write with a stray flash strobe, stray acks later.
        push_run();
        stall_target = 1;
        rst_n = 1'b1;
        n = 0;
        while (stall_cnt < 10 && n < 200) begin @(negedge clk28); n++; end
        stray_req++;
        n = 0;
        while (wr_idx < 4 && n < 400) begin @(negedge clk28); n++; end
        chk("chk_region1", 32'(checksum), 32'h000A);
        repeat (2) @(negedge clk28);
        stray_ack = 1'b1;
        repeat (12) @(negedge clk28);
        stray_ack = 1'b0;
        wait_end("run1_end", 2000);
        chk("run1_done", 32'(done), 32'd1);
        chk("run1_error", 32'(error), 32'd0);
        chk("run1_busy", 32'(busy), 32'd0);
        chk("run1_checksum", 32'(checksum), 32'h0014);
        chk("run1_writes", 32'(wr_idx), 32'd8);
        chk("run1_q", 32'(q_wr.size() + q_faddr.size()), 32'd0);
        base = req_cnt;
        repeat (20) @(negedge clk28);
        chk("done_sticky", 32'(done), 32'd1);
        chk("idle_no_req", 32'(req_cnt), 32'(base));

        // Run 2: restart from DONE, extra start pulses while busy must not disturb it.
        push_run();
        pulse_start();
        repeat (7) @(negedge clk28);
        chk("run2_busy", 32'(busy), 32'd1);
        pulse_start();
        repeat (13) @(negedge clk28);
        pulse_start();
        wait_end("run2_end", 2000);
        chk("run2_done", 32'(done), 32'd1);
        chk("run2_checksum", 32'(checksum), 32'h0014);
        chk("run2_writes", 32'(wr_idx), 32'd16);
        chk("run2_q", 32'(q_wr.size() + q_faddr.size()), 32'd0);

        // Run 3: flash goes silent at byte 2.
        answer_limit = answered + 1;
        q_faddr.push_back(24'h013256);
        q_faddr.push_back(24'h013257);
        q_wr.push_back({19'h00000, 8'h01});
        pulse_start();
        wait_end("run3_end", 500);
        chk("tmo_cycles", 32'(cyc - req_cyc), 32'd17);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_done", 32'(done), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_checksum", 32'(checksum), 32'h0001);
        base = req_cnt;
        repeat (40) @(negedge clk28);
        chk("tmo_no_req", 32'(req_cnt), 32'(base));
        chk("err_sticky", 32'(error), 32'd1);
        chk("tmo_q", 32'(q_wr.size() + q_faddr.size()), 32'd0);
        answer_limit = 1 << 30;
        push_run();
        pulse_start();
        chk("restart_error", 32'(error), 32'd0);
        chk("restart_checksum", 32'(checksum), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        wait_end("run4_end", 2000);
        chk("run4_done", 32'(done), 32'd1);
        chk("run4_checksum", 32'(checksum), 32'h0014);

        // Run 5: asynchronous reset in the middle of a stalled write, then auto restart.
        push_run();
        stall_target = wr_idx + 2;
        pulse_start();
        n = 0;
        while (stall_cnt != 10 && n < 300) begin @(negedge clk28); n++; end
        chk("rst_in_write", 32'(ram_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr", 32'(ram_wr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req", 32'(flash_req), 32'd0);
        chk("arst_raddr", 32'(ram_addr), 32'd0);
        chk("arst_rdata", 32'(ram_data), 32'd0);
        chk("arst_checksum", 32'(checksum), 32'd0);
        q_faddr.delete();
        q_wr.delete();
        stall_target = -1;
        repeat (2) @(negedge clk28);
        push_run();
        base = wr_idx;
        rst_n = 1'b1;
        wait_end("run5_end", 2000);
        chk("run5_done", 32'(done), 32'd1);
        chk("run5_checksum", 32'(checksum), 32'h0014);
        chk("run5_writes", 32'(wr_idx - base), 32'd8);
        chk("run5_q", 32'(q_wr.size() + q_faddr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
